// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and the byte/column helpers.
// A state byte at row r, column c lives at bits [32*r+8*c +: 8].
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;
  typedef byte_t [3:0]  col_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam byte_t RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t rcon_of(logic [3:0] k);
    byte_t v;
    v = 8'h00;
    if (k >= 4'd1 && k <= 4'd10) v = RCON[k];
    return v;
  endfunction

  function automatic col_t get_col(state_t s, int c);
    col_t v;
    for (int r = 0; r < 4; r++) v[r] = s[32*r + 8*c +: 8];
    return v;
  endfunction

  function automatic state_t shift_rows(state_t s);
    state_t o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[32*r + 8*c +: 8] = s[32*r + 8*((c + r) % 4) +: 8];
    return o;
  endfunction

  // Multiply by 3 is xtime(x)^x.
  function automatic col_t mix_column(col_t a);
    col_t o;
    o[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
    o[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
    o[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
    o[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock, key expanded on the fly; AES_ENC_LASTKEY_EN exports round key NR.
// Latency: out_valid NR cycles after the accepting edge; NR+2 cycles per block with out_ready held high.
// Backpressure: one block in flight, in_ready low until the ciphertext handshake completes; no input buffering.
module aes_encrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_vector,
  input  logic [127:0] key_vector,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_vector
`ifdef AES_ENC_LASTKEY_EN
  ,
  output logic [127:0] last_key
`endif
);
  import aes_pkg::*;

  localparam logic [3:0] NR_C = 4'(NR);

  fsm_t       r_fsm;
  fsm_t       w_fsm_nxt;
  logic [3:0] r_ctr;
  state_t     r_data;
  state_t     r_rk;

  state_t     w_sb;
  state_t     w_sr;
  state_t     w_mc;
  state_t     w_round;
  state_t     w_rk_nxt;
  col_t       w_rot;
  col_t       w_subw;
  logic       w_last;

  assign w_last = (r_ctr == NR_C);

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = ROUND;
      end
      ROUND: begin
        if (w_last) w_fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  for (genvar g = 0; g < 16; g++) begin : g_state_sbox
    aes_sbox u_sbox (.i_byte(r_data[8*g +: 8]), .o_byte(w_sb[8*g +: 8]));
  end

  // RotWord takes rows 1,2,3,0 of column 3.
  assign w_rot[0] = r_rk[63:56];
  assign w_rot[1] = r_rk[95:88];
  assign w_rot[2] = r_rk[127:120];
  assign w_rot[3] = r_rk[31:24];

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (.i_byte(w_rot[g]), .o_byte(w_subw[g]));
  end

  always_comb begin
    col_t w_acc;
    w_acc    = w_subw;
    w_acc[0] = w_subw[0] ^ rcon_of(r_ctr);
    w_rk_nxt = '0;
    for (int c = 0; c < 4; c++) begin
      w_acc = w_acc ^ get_col(r_rk, c);
      for (int r = 0; r < 4; r++) w_rk_nxt[32*r + 8*c +: 8] = w_acc[r];
    end
  end

  always_comb begin
    col_t w_col;
    w_col = '0;
    w_sr  = shift_rows(w_sb);
    w_mc  = '0;
    for (int c = 0; c < 4; c++) begin
      w_col = mix_column(get_col(w_sr, c));
      for (int r = 0; r < 4; r++) w_mc[32*r + 8*c +: 8] = w_col[r];
    end
    w_round = (w_last ? w_sr : w_mc) ^ w_rk_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rk   <= '0;
      r_ctr  <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_data <= pt_vector ^ key_vector;
            r_rk   <= key_vector;
            r_ctr  <= 4'd1;
          end
        end
        ROUND: begin
          r_data <= w_round;
          r_rk   <= w_rk_nxt;
          if (!w_last) r_ctr <= r_ctr + 4'd1;
        end
        DONE: begin
          if (out_ready) r_ctr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Intermediate round state never reaches the outputs.
  assign ct_vector = out_valid ? r_data : '0;
`ifdef AES_ENC_LASTKEY_EN
  assign last_key  = out_valid ? r_rk : '0;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: reference AES built from GF(2^8) arithmetic in FIPS byte order,
// a per-cycle transaction-timing scoreboard, directed FIPS-197 vectors and randomized traffic.
module tb_aes_encrypt_iter;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] pt_vector = '0;
  logic [127:0] key_vector = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] ct_vector;
`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] last_key;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_encrypt_iter #(.NR(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pt_vector  (pt_vector),
    .key_vector (key_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ct_vector  (ct_vector)
`ifdef AES_ENC_LASTKEY_EN
    ,
    .last_key   (last_key)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (FIPS byte order) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv, base;
    int e;
    inv = 8'h01; base = x; e = 254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 44; i++) w[i] = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*(r+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]) ^ rc, sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] rk, o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ key[127-8*k -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_m(s[k]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r + 4*((c+r)%4)];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      rk = round_key(key, rnd);
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[127-8*k -: 8];
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // FIPS byte k <-> row k%4, column k/4 of the port layout.
  function automatic logic [127:0] to_dut(input logic [127:0] f);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) d[32*(k%4) + 8*(k/4) +: 8] = f[127-8*k -: 8];
    return d;
  endfunction

  function automatic logic [127:0] from_dut(input logic [127:0] d);
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) f[127-8*k -: 8] = d[32*(k%4) + 8*(k/4) +: 8];
    return f;
  endfunction

  // ---------------- per-cycle scoreboard ----------------
  int           m_phase = 0;   // 0 idle, 1 busy, 2 result held
  int           m_left = 0;
  logic [127:0] m_ct = '0;
`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] m_lk = '0;
`endif

  always @(negedge clk) begin
    if (!rst_n) m_phase = 0;
    chk("in_ready", 128'(in_ready), 128'(m_phase == 0));
    chk("out_valid", 128'(out_valid), 128'(m_phase == 2));
    if (m_phase == 2) begin
      chk("ct_vector", ct_vector, m_ct);
`ifdef AES_ENC_LASTKEY_EN
      chk("last_key", last_key, m_lk);
`endif
    end
    if (rst_n) begin
      case (m_phase)
        0: if (in_valid) begin
          m_ct = to_dut(aes_ref(from_dut(pt_vector), from_dut(key_vector), NR));
`ifdef AES_ENC_LASTKEY_EN
          m_lk = to_dut(round_key(from_dut(key_vector), NR));
`endif
          m_left = NR;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] p, input logic [127:0] k, output int t);
    t = -1;
    @(posedge clk); #2;
    pt_vector = p; key_vector = k; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #2;
        t = cyc;
        in_valid = 1'b0;
        break;
      end
    end
    if (t < 0) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready never seen (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_valid(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_chk++;
      $display("FAIL valid_timeout: out_valid never seen (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL idle_timeout: in_ready never returned (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [127:0] b_pt, b_key, b_ct, c_pt, c_key, c_ct, lk_b;
    int t_acc, t_acc2, t_v, t_v2;

    b_pt  = 128'h3243f6a8885a308d313198a2e0370734;
    b_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    b_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    lk_b  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    c_pt  = 128'h00112233445566778899aabbccddeeff;
    c_key = 128'h000102030405060708090a0b0c0d0e0f;
    c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Pin the reference model to the published vectors.
    chk("model_appB_ct", aes_ref(b_pt, b_key, 10), b_ct);
    chk("model_appC1_ct", aes_ref(c_pt, c_key, 10), c_ct);
    chk("model_appB_rk10", round_key(b_key, 10), lk_b);
    chk("model_sbox_53", 128'(sbox_m(8'h53)), 128'(8'hed));

    // Reset state.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_ct", ct_vector, 128'h0);
`ifdef AES_ENC_LASTKEY_EN
    chk("reset_last_key", last_key, 128'h0);
`endif

    // App.B with 20 cycles of backpressure.
    out_ready = 1'b0;
    send(to_dut(b_pt), to_dut(b_key), t_acc);
    wait_valid(t_v);
    chk("appB_latency", 128'(t_v), 128'(t_acc + NR));
    chk("appB_ct", ct_vector, to_dut(b_ct));
`ifdef AES_ENC_LASTKEY_EN
    chk("appB_last_key", last_key, to_dut(lk_b));
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_ct_stable", ct_vector, to_dut(b_ct));
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_idle", 128'(in_ready), 128'(1));
    chk("bp_release_valid", 128'(out_valid), 128'(0));

    // App.C.1 with a second block offered mid-round and held.
    out_ready = 1'b1;
    send(to_dut(c_pt), to_dut(c_key), t_acc);
    repeat (3) @(posedge clk);
    #2;
    in_valid = 1'b1;
    pt_vector = {$urandom, $urandom, $urandom, $urandom};
    key_vector = {$urandom, $urandom, $urandom, $urandom};
    wait_valid(t_v);
    chk("appC1_latency", 128'(t_v), 128'(t_acc + NR));
    chk("appC1_ct", ct_vector, to_dut(c_ct));
    @(negedge clk);
    chk("second_waits_for_idle", 128'(in_ready), 128'(1));
    @(posedge clk); #2;
    t_acc2 = cyc;
    in_valid = 1'b0;
    wait_valid(t_v2);
    chk("second_latency", 128'(t_v2), 128'(t_acc2 + NR));
    wait_idle();

    // Reset in the middle of a block.
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, t_acc);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", 128'(in_ready), 128'(1));
    chk("midreset_out_valid", 128'(out_valid), 128'(0));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midreset_no_output", 128'(out_valid), 128'(0));
    end
    send(to_dut(c_pt), to_dut(c_key), t_acc);
    wait_valid(t_v);
    chk("postreset_latency", 128'(t_v), 128'(t_acc + NR));
    chk("postreset_ct", ct_vector, to_dut(c_ct));
    wait_idle();

    // Back-to-back App.B blocks with out_ready held high.
    @(posedge clk); #2;
    pt_vector = to_dut(b_pt); key_vector = to_dut(b_key);
    in_valid = 1'b1; out_ready = 1'b1;
    wait_valid(t_v);
    chk("b2b_first_ct", ct_vector, to_dut(b_ct));
    @(negedge clk);
    wait_valid(t_v2);
    chk("b2b_second_ct", ct_vector, to_dut(b_ct));
    chk("b2b_gap", 128'(t_v2 - t_v), 128'(NR + 2));
    @(posedge clk); #2 in_valid = 1'b0;
    wait_idle();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      in_valid   = 1'($urandom_range(0, 1));
      pt_vector  = {$urandom, $urandom, $urandom, $urandom};
      key_vector = {$urandom, $urandom, $urandom, $urandom};
      out_ready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
